// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 round controller: walks the shared round datapath through the
// initial AddRoundKey plus NR rounds, fetching one round key per step.
module aes_round_sequencer #(
    parameter int unsigned NR = 10,
    parameter int unsigned RW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          enc_dec_in,
    input  logic          abort,
    output logic          ready,
    output logic          enc_dec,
    output logic          key_req,
    output logic [RW-1:0] key_idx,
    input  logic          key_ack,
    output logic          ld_input,
    output logic          ld_round,
    output logic          mix_en,
    output logic [RW-1:0] round_idx,
    output logic          out_valid,
    input  logic          out_ready
);

    localparam logic [RW-1:0] NR_IDX   = RW'(NR);
    localparam logic [RW-1:0] LAST_MIX = RW'(NR - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_ROUND = 3'd2,
        S_FINAL = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic            enc_dec_q, enc_dec_d;
    logic [RW-1:0]   round_idx_q, round_idx_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            enc_dec_q   <= 1'b1;
            round_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            enc_dec_q   <= enc_dec_d;
            round_idx_q <= round_idx_d;
        end
    end

    // Next-state logic and key_ack-qualified load strobes; abort overrides everything.
    always_comb begin
        state_d     = state_q;
        enc_dec_d   = enc_dec_q;
        round_idx_d = round_idx_q;
        ld_input    = 1'b0;
        ld_round    = 1'b0;
        if (abort) begin
            state_d     = S_IDLE;
            round_idx_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        enc_dec_d   = enc_dec_in;
                        round_idx_d = '0;
                        state_d     = S_INIT;
                    end
                end
                S_INIT: begin
                    if (key_ack) begin
                        ld_input    = 1'b1;
                        round_idx_d = RW'(1);
                        state_d     = S_ROUND;
                    end
                end
                S_ROUND: begin
                    if (key_ack) begin
                        ld_round    = 1'b1;
                        round_idx_d = round_idx_q + RW'(1);
                        if (round_idx_q == LAST_MIX) begin
                            state_d = S_FINAL;
                        end
                    end
                end
                S_FINAL: begin
                    if (key_ack) begin
                        ld_round = 1'b1;
                        state_d  = S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        round_idx_d = '0;
                        state_d     = S_IDLE;
                    end
                end
                default: begin
                    state_d     = S_IDLE;
                    round_idx_d = '0;
                end
            endcase
        end
    end

    // Key index counts down when decrypting so the schedule is walked in reverse.
    always_comb begin
        ready     = 1'b0;
        key_req   = 1'b0;
        key_idx   = '0;
        mix_en    = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            S_IDLE: ready = 1'b1;
            S_INIT: begin
                key_req = 1'b1;
                key_idx = enc_dec_q ? '0 : NR_IDX;
            end
            S_ROUND: begin
                key_req = 1'b1;
                key_idx = enc_dec_q ? round_idx_q : (NR_IDX - round_idx_q);
                mix_en  = 1'b1;
            end
            S_FINAL: begin
                key_req = 1'b1;
                key_idx = enc_dec_q ? NR_IDX : '0;
            end
            S_DONE: out_valid = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    assign enc_dec   = enc_dec_q;
    assign round_idx = round_idx_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed cycle-exact checks of the AES round sequencer control timing.
module tb_aes_round_sequencer;

    localparam int unsigned NR = 10;
    localparam int unsigned RW = 4;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          enc_dec_in;
    logic          abort;
    logic          ready;
    logic          enc_dec;
    logic          key_req;
    logic [RW-1:0] key_idx;
    logic          key_ack;
    logic          ld_input;
    logic          ld_round;
    logic          mix_en;
    logic [RW-1:0] round_idx;
    logic          out_valid;
    logic          out_ready;

    int total = 0;
    int bad   = 0;

    aes_round_sequencer #(.NR(NR), .RW(RW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .enc_dec_in (enc_dec_in),
        .abort      (abort),
        .ready      (ready),
        .enc_dec    (enc_dec),
        .key_req    (key_req),
        .key_idx    (key_idx),
        .key_ack    (key_ack),
        .ld_input   (ld_input),
        .ld_round   (ld_round),
        .mix_en     (mix_en),
        .round_idx  (round_idx),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"},  32'(ready),     32'd1);
        chk({tag, "_enc"},    32'(enc_dec),   32'd1);
        chk({tag, "_req"},    32'(key_req),   32'd0);
        chk({tag, "_kidx"},   32'(key_idx),   32'd0);
        chk({tag, "_ldin"},   32'(ld_input),  32'd0);
        chk({tag, "_ldrd"},   32'(ld_round),  32'd0);
        chk({tag, "_mix"},    32'(mix_en),    32'd0);
        chk({tag, "_ridx"},   32'(round_idx), 32'd0);
        chk({tag, "_ovld"},   32'(out_valid), 32'd0);
    endtask

    // One full block: optional key_ack stall in one round, optional out_ready hold in DONE.
    task automatic run_block(input logic enc, input int stall_rnd, input int stall_len,
                             input int hold_len);
        start = 1'b1; enc_dec_in = enc; key_ack = 1'b1; out_ready = 1'b0; abort = 1'b0;
        #1;
        chk("idle_ready", 32'(ready), 32'd1);
        tick();
        start = 1'b0;
        #1;
        chk("init_req",  32'(key_req),   32'd1);
        chk("init_kidx", 32'(key_idx),   enc ? 32'd0 : 32'(NR));
        chk("init_ldin", 32'(ld_input),  32'd1);
        chk("init_ldrd", 32'(ld_round),  32'd0);
        chk("init_ridx", 32'(round_idx), 32'd0);
        chk("init_enc",  32'(enc_dec),   32'(enc));
        chk("init_rdy",  32'(ready),     32'd0);
        tick();
        for (int r = 1; r <= int'(NR); r++) begin
            if (r == stall_rnd) begin
                for (int s = 0; s < stall_len; s++) begin
                    key_ack = 1'b0;
                    #1;
                    chk("stall_req",  32'(key_req),  32'd1);
                    chk("stall_kidx", 32'(key_idx),  enc ? 32'(r) : 32'(int'(NR) - r));
                    chk("stall_mix",  32'(mix_en),   32'(r < int'(NR)));
                    chk("stall_ldrd", 32'(ld_round), 32'd0);
                    chk("stall_ovld", 32'(out_valid), 32'd0);
                    tick();
                end
                key_ack = 1'b1;
            end
            #1;
            chk("rnd_req",  32'(key_req),   32'd1);
            chk("rnd_kidx", 32'(key_idx),   enc ? 32'(r) : 32'(int'(NR) - r));
            chk("rnd_mix",  32'(mix_en),    32'(r < int'(NR)));
            chk("rnd_ridx", 32'(round_idx), 32'(r));
            chk("rnd_ldrd", 32'(ld_round),  32'd1);
            chk("rnd_ldin", 32'(ld_input),  32'd0);
            chk("rnd_enc",  32'(enc_dec),   32'(enc));
            chk("rnd_ovld", 32'(out_valid), 32'd0);
            tick();
        end
        for (int h = 0; h < hold_len; h++) begin
            start = 1'b1; enc_dec_in = ~enc;
            #1;
            chk("hold_ovld", 32'(out_valid), 32'd1);
            chk("hold_rdy",  32'(ready),     32'd0);
            chk("hold_req",  32'(key_req),   32'd0);
            chk("hold_enc",  32'(enc_dec),   32'(enc));
            tick();
        end
        start = 1'b0; out_ready = 1'b1;
        #1;
        chk("done_ovld", 32'(out_valid), 32'd1);
        chk("done_rdy",  32'(ready),     32'd0);
        chk("done_ldrd", 32'(ld_round),  32'd0);
        tick();
        out_ready = 1'b0;
        #1;
        chk("post_ovld", 32'(out_valid), 32'd0);
        chk("post_rdy",  32'(ready),     32'd1);
        chk("post_enc",  32'(enc_dec),   32'(enc));
        chk("post_ridx", 32'(round_idx), 32'd0);
    endtask

    initial begin
        rst_n = 1'b1; start = 1'b0; enc_dec_in = 1'b1; abort = 1'b0;
        key_ack = 1'b0; out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs("rst");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk_reset_outputs("idle");

        run_block(1'b1, 0, 0, 0);
        run_block(1'b0, 0, 0, 0);
        run_block(1'b1, 5, 3, 0);
        run_block(1'b0, 0, 0, 4);

        // Abort in round 7 coincident with key_ack.
        tick();
        start = 1'b1; enc_dec_in = 1'b0; key_ack = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        abort = 1'b1;
        #1;
        chk("abort_ridx", 32'(round_idx), 32'd7);
        chk("abort_ldrd", 32'(ld_round),  32'd0);
        tick();
        abort = 1'b0;
        #1;
        chk("abort_rdy",  32'(ready),     32'd1);
        chk("abort_req",  32'(key_req),   32'd0);
        chk("abort_ridx0", 32'(round_idx), 32'd0);
        chk("abort_ovld", 32'(out_valid), 32'd0);
        run_block(1'b1, 0, 0, 0);

        // Abort together with start in IDLE: start is ignored.
        tick();
        abort = 1'b1; start = 1'b1; enc_dec_in = 1'b0;
        tick();
        abort = 1'b0; start = 1'b0;
        #1;
        chk("idle_abort_rdy", 32'(ready),   32'd1);
        chk("idle_abort_enc", 32'(enc_dec), 32'd1);
        chk("idle_abort_req", 32'(key_req), 32'd0);

        // Asynchronous reset in round 4 of a decrypt block.
        tick();
        start = 1'b1; enc_dec_in = 1'b0; key_ack = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("mid_ridx", 32'(round_idx), 32'd4);
        chk("mid_enc",  32'(enc_dec),   32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs("async");
        tick();
        #2 rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("after_rst_ovld", 32'(out_valid), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_round_sequencer.md
Name: aes_round_sequencer

Overview:
- Iterative AES-128 round controller. Sequences the shared round datapath (SubBytes/ShiftRows/MixColumns/AddRoundKey) across the initial key addition plus NR rounds, for both encryption and decryption.
- Drives the datapath mode bit, mux/enable strobes and round-key index.
- Handshakes with the key-schedule block for each round key and with the downstream consumer for the result.

Parameters:
- NR, 10, number of full rounds; final round omits (Inv)MixColumns. Must be ≥2 and ≤15.
- RW, 4, width of round index; must satisfy 2^RW > NR.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request to process a block; accepted only when ready=1
- enc_dec_in  in  1  mode for the request (1 = encrypt, 0 = decrypt); sampled with start
- abort  in  1  synchronous abort; returns FSM to IDLE
- ready  out  1  high in IDLE; block can be accepted
- enc_dec  out  1  latched mode to datapath (ShiftRows/SubBytes/MixColumns direction)
- key_req  out  1  round-key request to key schedule
- key_idx  out  RW  index of requested round key
- key_ack  in  1  key schedule presents key key_idx this cycle
- ld_input  out  1  datapath loads plaintext XOR key (initial AddRoundKey)
- ld_round  out  1  datapath state register captures round output
- mix_en  out  1  route through (Inv)MixColumns; 0 bypasses it
- round_idx  out  RW  current round number, 0..NR
- out_valid  out  1  result in datapath state register is valid
- out_ready  in  1  consumer accepts result

Behaviour:
- Reset (async, rst_n=0): state = IDLE. ready=1, enc_dec=1, key_req=0, key_idx=0, ld_input=0, ld_round=0, mix_en=0, round_idx=0, out_valid=0. Reset mid-operation discards the block with no out_valid.
- States: IDLE, INIT, ROUND, FINAL, DONE.
- IDLE:
  - start=1 latches enc_dec_in into enc_dec, sets round_idx=0 and goes to INIT.
  - start=0 stays in IDLE.
- INIT:
  - key_req=1, key_idx = 0 (enc) or NR (dec).
  - On key_ack: ld_input=1 for that cycle, round_idx←1, then go to ROUND (or FINAL if NR=1; not supported).
  - No key_ack: hold, strobes 0.
- ROUND (round_idx 1..NR-1):
  - key_req=1, key_idx = round_idx (enc) or NR-round_idx (dec), mix_en=1.
  - On key_ack: ld_round=1 and round_idx increments. If the new value equals NR, go to FINAL.
- FINAL:
  - key_req=1, key_idx = NR (enc) or 0 (dec), mix_en=0.
  - On key_ack: ld_round=1, go to DONE.
- DONE:
  - out_valid=1, held stable until out_ready=1.
  - On out_valid&out_ready: go to IDLE, out_valid deasserts next cycle.
  - Back-to-back: start is ignored in DONE; ready is only high in IDLE.
- Strobes:
  - ld_input and ld_round are combinational AND of state and key_ack; they are never high together.
  - key_req, key_idx and mix_en are registered-state decodes, stable while waiting for key_ack.
- abort: in any non-IDLE state, next state = IDLE with all strobes low. It takes priority over key_ack and out_ready in the same cycle. In IDLE, abort with start: abort wins and start is ignored.
- Latency with key_ack tied high: start accepted at cycle T gives INIT at T+1, rounds at T+2..T+NR+1, and out_valid high at T+NR+2 (12 cycles for NR=10).
- Each cycle key_ack is low in INIT/ROUND/FINAL adds exactly one cycle of latency.
- enc_dec does not change outside IDLE.
- round_idx never exceeds NR and never wraps.

Test Plan:
- Encrypt, key_ack=1, out_ready=1: start with enc_dec_in=1 at cycle 0 → key_idx sequence 0,1,…,10; mix_en=1 for rounds 1–9 and 0 for round 10; ld_input at cycle 1; ld_round at cycles 2–11; out_valid at cycle 12 for one cycle; FIPS-197 C.1 vector 00112233…eeff / key 0001…0f → 69c4e0d8…c55a with the datapath attached.
- Decrypt, same setup: key_idx sequence 10,9,…,0; enc_dec=0 throughout; C.1 ciphertext decrypts back to plaintext; out_valid at cycle 12.
- key_ack low for 3 cycles in round 5 → key_req, key_idx=5 and mix_en held; no ld_round during the stall; out_valid delayed to cycle 15.
- out_ready low 4 cycles in DONE → out_valid held; ready=0; start pulses ignored; IDLE entered the cycle after out_ready=1.
- abort in round 7 coincident with key_ack → no ld_round; IDLE next cycle; ready=1; a new start runs a full 12-cycle block correctly.
- rst_n low mid-round 4 → all outputs at reset values immediately (asynchronous); no out_valid after release.
